spi_xfer_seq: RTL

// - Sequences one SPI transfer of N bytes between a TX byte FIFO and an RX byte FIFO (32-deep fifo instances).
// - Pops TX bytes, shifts them out MSB-first in SPI mode 0, and pushes the captured MISO bytes into the RX FIFO.
// - Sits between the host register interface (start/len/mode/clk_div) and the SD card pins.

---
 rtl/spi_xfer_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_seq.sv
// SPI mode-0 byte sequencer between TX/RX FIFOs and the card pins; 1 LOAD + 16*(clk_div+1) + 1 STORE cycles per byte.
// Stalls in LOAD while the TX FIFO is empty or the RX FIFO is full; define SPI_CRC16_EN for a CRC16-CCITT of mosi.
module spi_xfer_seq #(
  parameter int LEN_W = 10,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       tx_q,
  input  logic             tx_empty,
  output logic             tx_rdreq,
  input  logic             rx_full,
  output logic             rx_wrreq,
  output logic [7:0]       rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [15:0]      crc16
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_STORE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [1:0]       mode_r, mode_nxt;
  logic [DIV_W-1:0] div_r, div_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       rx_data_nxt;
  logic             busy_nxt, done_nxt, tx_rdreq_nxt, rx_wrreq_nxt, sclk_nxt, mosi_nxt;

  logic       tx_used, rx_used, load_go, div_end, aborting, start_ok;
  logic [7:0] load_byte;

  assign tx_used   = (mode_r != 2'b01);
  assign rx_used   = (mode_r != 2'b00);
  assign load_go   = !((tx_used && tx_empty) || (rx_used && rx_full));
  assign div_end   = (div_cnt == div_r);
  assign aborting  = abort && (state != S_IDLE);
  assign start_ok  = (state == S_IDLE) && start && !abort && (len != '0);
  assign load_byte = tx_used ? tx_q : 8'hFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (aborting) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_ok) state_nxt = S_LOAD;
        S_LOAD:  if (load_go) state_nxt = S_LOW;
        S_LOW:   if (div_end) state_nxt = S_HIGH;
        S_HIGH:  if (div_end) state_nxt = (bit_cnt == 3'd7) ? S_STORE : S_LOW;
        S_STORE: state_nxt = (remaining == LEN_W'(1)) ? S_IDLE : S_LOAD;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    tx_rdreq_nxt  = 1'b0;
    rx_wrreq_nxt  = 1'b0;
    rx_data_nxt   = rx_data;
    sclk_nxt      = sclk;
    mosi_nxt      = mosi;
    remaining_nxt = remaining;
    mode_nxt      = mode_r;
    div_nxt       = div_r;
    div_cnt_nxt   = div_cnt;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    if (aborting) begin
      busy_nxt = 1'b0;
      sclk_nxt = 1'b0;
      mosi_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (len == '0) begin
              done_nxt = 1'b1;
            end else begin
              busy_nxt      = 1'b1;
              remaining_nxt = len;
              mode_nxt      = mode;
              div_nxt       = clk_div;
            end
          end
        end
        S_LOAD: begin
          if (load_go) begin
            shreg_nxt    = load_byte;
            tx_rdreq_nxt = tx_used;
            mosi_nxt     = load_byte[7];
            div_cnt_nxt  = '0;
            bit_cnt_nxt  = 3'd0;
          end
        end
        S_LOW: begin
          // Rising edge: the bit on mosi leaves shreg[7] as miso enters at the LSB.
          if (div_end) begin
            sclk_nxt    = 1'b1;
            div_cnt_nxt = '0;
            shreg_nxt   = {shreg[6:0], miso};
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (div_end) begin
            sclk_nxt    = 1'b0;
            div_cnt_nxt = '0;
            if (bit_cnt != 3'd7) begin
              bit_cnt_nxt = bit_cnt + 3'd1;
              mosi_nxt    = shreg[7];
            end
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
        S_STORE: begin
          if (rx_used) begin
            rx_data_nxt  = shreg;
            rx_wrreq_nxt = 1'b1;
          end
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
            mosi_nxt = 1'b1;
          end
        end
        default: begin
          busy_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_rdreq  <= 1'b0;
      rx_wrreq  <= 1'b0;
      rx_data   <= 8'h00;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      remaining <= '0;
      mode_r    <= 2'b00;
      div_r     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      tx_rdreq  <= tx_rdreq_nxt;
      rx_wrreq  <= rx_wrreq_nxt;
      rx_data   <= rx_data_nxt;
      sclk      <= sclk_nxt;
      mosi      <= mosi_nxt;
      remaining <= remaining_nxt;
      mode_r    <= mode_nxt;
      div_r     <= div_nxt;
      div_cnt   <= div_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
    end
  end

`ifdef SPI_CRC16_EN
  logic [15:0] crc_r;
  logic        crc_adv;

  // Advances on the cycle sclk rises, using the bit currently on mosi.
  assign crc_adv = (state == S_LOW) && div_end && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_r <= 16'h0000;
    end else if (start_ok) begin
      crc_r <= 16'h0000;
    end else if (crc_adv) begin
      crc_r <= {crc_r[14:0], 1'b0} ^ ((crc_r[15] ^ mosi) ? 16'h1021 : 16'h0000);
    end
  end

  assign crc16 = crc_r;
`else
  assign crc16 = 16'h0000;
`endif

endmodule
